// File: rtl/sys_ctrl_mc.sv
// sys_ctrl_mc
// Command-frame controller between the RX synchroniser and the register
// file, ALU and TX FIFO. Opcode-led byte frames become register writes,
// single or burst register reads, or ALU operations. Wide results are
// serialised into the TX FIFO LSB-first. Frame timeout, error pulses and a
// busy flag are included. Every output is a register.
module sys_ctrl_mc #(
  parameter int unsigned     DW          = 8,
  parameter int unsigned     ADDR_W      = 4,
  parameter int unsigned     FUN_W       = 4,
  parameter int unsigned     RES_BEATS   = 2,
  parameter int unsigned     TO_W        = 16,
  parameter logic [TO_W-1:0] TO_LIMIT    = 16'hFFFF,
  parameter logic [DW-1:0]   OPC_WR      = 8'hAA,
  parameter logic [DW-1:0]   OPC_RD      = 8'hBB,
  parameter logic [DW-1:0]   OPC_ALU_OP  = 8'hCC,
  parameter logic [DW-1:0]   OPC_ALU_NOP = 8'hDD,
  parameter logic [DW-1:0]   OPC_BURST   = 8'hEE
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DW-1:0]           rx_data,
  input  logic                    rx_valid,
  input  logic                    fifo_full,
  input  logic [RES_BEATS*DW-1:0] alu_out,
  input  logic                    alu_out_valid,
  input  logic [DW-1:0]           rf_rd_data,
  input  logic                    rf_rd_valid,
  output logic [DW-1:0]           fifo_wr_data,
  output logic                    fifo_wr_en,
  output logic [ADDR_W-1:0]       rf_addr,
  output logic [DW-1:0]           rf_wr_data,
  output logic                    rf_wr_en,
  output logic                    rf_rd_en,
  output logic                    alu_en,
  output logic [FUN_W-1:0]        alu_fun,
  output logic                    gate_en,
  output logic                    busy,
  output logic                    err_opcode,
  output logic                    err_timeout
);

  localparam int unsigned RES_W  = RES_BEATS * DW;
  localparam int unsigned BEAT_W = $clog2(RES_BEATS + 1);
  // One extra bit so a burst count of zero can stand for 2^DW reads.
  localparam int unsigned CNT_W  = DW + 1;

  localparam logic [3:0] S_IDLE       = 4'd0;
  localparam logic [3:0] S_WR_ADDR    = 4'd1;
  localparam logic [3:0] S_WR_DATA    = 4'd2;
  localparam logic [3:0] S_RD_ADDR    = 4'd3;
  localparam logic [3:0] S_BURST_ADDR = 4'd4;
  localparam logic [3:0] S_BURST_CNT  = 4'd5;
  localparam logic [3:0] S_RD_REQ     = 4'd6;
  localparam logic [3:0] S_RD_WAIT    = 4'd7;
  localparam logic [3:0] S_OPA        = 4'd8;
  localparam logic [3:0] S_OPB        = 4'd9;
  localparam logic [3:0] S_FUN        = 4'd10;
  localparam logic [3:0] S_ALU_WAIT   = 4'd11;
  localparam logic [3:0] S_TX         = 4'd12;

  logic [3:0]        state;
  logic [3:0]        state_next;
  logic              timed;      // current state is subject to frame timeout
  logic              to_hit;     // timeout fires this cycle
  logic              last_beat;  // final TX beat is written this cycle
  logic [TO_W-1:0]   to_cnt;
  logic [CNT_W-1:0]  rd_cnt;     // reads still to perform, current one included
  logic              rd_mode;    // TX drains back into the read loop
  logic [RES_W-1:0]  tx_buf;     // pending result, next beat in the low slice
  logic [BEAT_W-1:0] beats_left;

  // Next-state decode, timeout detection and TX completion.
  always_comb begin
    // NOTE: every variable gets a default first, so no path can infer a latch.
    state_next = state;
    timed      = 1'b0;
    last_beat  = 1'b0;
    case (state)
      S_IDLE: begin
        if (rx_valid) begin
          if (rx_data == OPC_WR)           state_next = S_WR_ADDR;
          else if (rx_data == OPC_RD)      state_next = S_RD_ADDR;
          else if (rx_data == OPC_ALU_OP)  state_next = S_OPA;
          else if (rx_data == OPC_ALU_NOP) state_next = S_FUN;
          else if (rx_data == OPC_BURST)   state_next = S_BURST_ADDR;
        end
      end
      S_WR_ADDR: begin
        timed = 1'b1;
        if (rx_valid) state_next = S_WR_DATA;
      end
      S_WR_DATA: begin
        timed = 1'b1;
        if (rx_valid) state_next = S_IDLE;
      end
      S_RD_ADDR: begin
        timed = 1'b1;
        if (rx_valid) state_next = S_RD_REQ;
      end
      S_BURST_ADDR: begin
        timed = 1'b1;
        if (rx_valid) state_next = S_BURST_CNT;
      end
      S_BURST_CNT: begin
        timed = 1'b1;
        if (rx_valid) state_next = S_RD_REQ;
      end
      S_RD_REQ: begin
        state_next = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (rf_rd_valid) state_next = S_TX;
      end
      S_OPA: begin
        timed = 1'b1;
        if (rx_valid) state_next = S_OPB;
      end
      S_OPB: begin
        timed = 1'b1;
        if (rx_valid) state_next = S_FUN;
      end
      S_FUN: begin
        timed = 1'b1;
        if (rx_valid) state_next = S_ALU_WAIT;
      end
      S_ALU_WAIT: begin
        if (alu_out_valid) state_next = S_TX;
      end
      S_TX: begin
        last_beat = !fifo_full && (beats_left == BEAT_W'(1));
        if (last_beat) begin
          state_next = (rd_mode && (rd_cnt != CNT_W'(1))) ? S_RD_REQ : S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase

    // A silent frame state that has waited long enough abandons the command.
    to_hit = timed && !rx_valid && (to_cnt == TO_LIMIT);
    if (to_hit) state_next = S_IDLE;
  end

  // State register and the inter-frame idle counter.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state  <= S_IDLE;
      to_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments make every register sample pre-edge values.
      state <= state_next;
      if (!timed || rx_valid || (state_next != state)) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + TO_W'(1);
      end
    end
  end

  // Datapath registers and all registered outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      fifo_wr_data <= '0;
      fifo_wr_en   <= 1'b0;
      rf_addr      <= '0;
      rf_wr_data   <= '0;
      rf_wr_en     <= 1'b0;
      rf_rd_en     <= 1'b0;
      alu_en       <= 1'b0;
      alu_fun      <= '0;
      gate_en      <= 1'b0;
      busy         <= 1'b0;
      err_opcode   <= 1'b0;
      err_timeout  <= 1'b0;
      rd_cnt       <= '0;
      rd_mode      <= 1'b0;
      tx_buf       <= '0;
      beats_left   <= '0;
    end else begin
      // Strobes default low; level outputs follow the state being entered.
      fifo_wr_en  <= 1'b0;
      rf_wr_en    <= 1'b0;
      alu_en      <= 1'b0;
      err_opcode  <= 1'b0;
      err_timeout <= to_hit;
      rf_rd_en    <= (state_next == S_RD_REQ);
      busy        <= (state_next != S_IDLE);
      gate_en     <= (state_next == S_FUN) || (state_next == S_ALU_WAIT);

      case (state)
        S_IDLE: begin
          if (rx_valid) begin
            rd_mode    <= (rx_data == OPC_RD) || (rx_data == OPC_BURST);
            err_opcode <= (state_next == S_IDLE);
          end
        end
        S_WR_ADDR: begin
          if (rx_valid) rf_addr <= rx_data[ADDR_W-1:0];
        end
        S_WR_DATA: begin
          if (rx_valid) begin
            rf_wr_data <= rx_data;
            rf_wr_en   <= 1'b1;
          end
        end
        S_RD_ADDR: begin
          if (rx_valid) begin
            rf_addr <= rx_data[ADDR_W-1:0];
            rd_cnt  <= CNT_W'(1);
          end
        end
        S_BURST_ADDR: begin
          if (rx_valid) rf_addr <= rx_data[ADDR_W-1:0];
        end
        S_BURST_CNT: begin
          if (rx_valid) begin
            rd_cnt <= (rx_data == '0) ? {1'b1, {DW{1'b0}}} : {1'b0, rx_data};
          end
        end
        S_RD_WAIT: begin
          if (rf_rd_valid) begin
            tx_buf     <= RES_W'(rf_rd_data);
            beats_left <= BEAT_W'(1);
          end
        end
        S_OPA: begin
          if (rx_valid) begin
            rf_addr    <= ADDR_W'(0);
            rf_wr_data <= rx_data;
            rf_wr_en   <= 1'b1;
          end
        end
        S_OPB: begin
          if (rx_valid) begin
            rf_addr    <= ADDR_W'(1);
            rf_wr_data <= rx_data;
            rf_wr_en   <= 1'b1;
          end
        end
        S_FUN: begin
          if (rx_valid) begin
            alu_fun <= rx_data[FUN_W-1:0];
            alu_en  <= 1'b1;
          end
        end
        S_ALU_WAIT: begin
          if (alu_out_valid) begin
            tx_buf     <= alu_out;
            beats_left <= BEAT_W'(RES_BEATS);
          end
        end
        S_TX: begin
          // A full FIFO holds the current beat in tx_buf untouched.
          if (!fifo_full) begin
            fifo_wr_en   <= 1'b1;
            fifo_wr_data <= tx_buf[DW-1:0];
            tx_buf       <= tx_buf >> DW;
            beats_left   <= beats_left - BEAT_W'(1);
            if (last_beat && rd_mode) begin
              rd_cnt  <= rd_cnt - CNT_W'(1);
              rf_addr <= rf_addr + ADDR_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sys_ctrl_mc.sv
// tb_sys_ctrl_mc
// Self-checking bench for sys_ctrl_mc. Commands are modelled at transaction
// level: each command pushes the register writes, read addresses, ALU
// functions and FIFO bytes it must produce; monitors consume them in order.
module tb_sys_ctrl_mc;

  localparam int unsigned     DW        = 8;
  localparam int unsigned     ADDR_W    = 4;
  localparam int unsigned     FUN_W     = 4;
  localparam int unsigned     RES_BEATS = 2;
  localparam int unsigned     TO_W      = 8;
  localparam logic [TO_W-1:0] TO_LIMIT  = 8'd40;

  logic                    CLK = 1'b0;
  logic                    RST;
  logic [DW-1:0]           rx_data;
  logic                    rx_valid;
  logic                    fifo_full;
  logic [RES_BEATS*DW-1:0] alu_out;
  logic                    alu_out_valid;
  logic [DW-1:0]           rf_rd_data;
  logic                    rf_rd_valid;
  logic [DW-1:0]           fifo_wr_data;
  logic                    fifo_wr_en;
  logic [ADDR_W-1:0]       rf_addr;
  logic [DW-1:0]           rf_wr_data;
  logic                    rf_wr_en;
  logic                    rf_rd_en;
  logic                    alu_en;
  logic [FUN_W-1:0]        alu_fun;
  logic                    gate_en;
  logic                    busy;
  logic                    err_opcode;
  logic                    err_timeout;

  sys_ctrl_mc #(
    .DW(DW), .ADDR_W(ADDR_W), .FUN_W(FUN_W), .RES_BEATS(RES_BEATS),
    .TO_W(TO_W), .TO_LIMIT(TO_LIMIT)
  ) dut (
    .CLK(CLK), .RST(RST), .rx_data(rx_data), .rx_valid(rx_valid),
    .fifo_full(fifo_full), .alu_out(alu_out), .alu_out_valid(alu_out_valid),
    .rf_rd_data(rf_rd_data), .rf_rd_valid(rf_rd_valid),
    .fifo_wr_data(fifo_wr_data), .fifo_wr_en(fifo_wr_en), .rf_addr(rf_addr),
    .rf_wr_data(rf_wr_data), .rf_wr_en(rf_wr_en), .rf_rd_en(rf_rd_en),
    .alu_en(alu_en), .alu_fun(alu_fun), .gate_en(gate_en), .busy(busy),
    .err_opcode(err_opcode), .err_timeout(err_timeout)
  );

  always #5 CLK = ~CLK;

  logic [31:0] outs;
  assign outs = {fifo_wr_data, fifo_wr_en, rf_addr, rf_wr_data, rf_wr_en, rf_rd_en,
                 alu_en, alu_fun, gate_en, busy, err_opcode, err_timeout};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model: expected transactions (pushed by stimulus only) and
  // monitor read pointers (advanced by the monitor only).
  logic [DW-1:0]     rf_mem [16];
  logic [11:0]       exp_wr[$];
  logic [3:0]        exp_rd[$];
  logic [7:0]        exp_fifo[$];
  logic [3:0]        exp_fun[$];
  int wr_idx = 0, rd_idx = 0, fifo_idx = 0, fun_idx = 0;
  int exp_err_op = 0, obs_err_op = 0, exp_err_to = 0, obs_err_to = 0;
  int fifo_writes = 0;
  logic [15:0] alu_result = 16'h0;
  bit   alu_hold  = 1'b0;
  int   full_mode = 0;     // 0: never full, 1: always full, 2: random
  int   max_gap   = 0;
  logic full_q;

  localparam logic [7:0] OPC_WR = 8'hAA, OPC_RD = 8'hBB, OPC_ALU_OP = 8'hCC,
                         OPC_ALU_NOP = 8'hDD, OPC_BURST = 8'hEE;

  // FIFO full level as the DUT saw it at the last rising edge.
  always @(posedge CLK) full_q <= fifo_full;

  // Register file and ALU stand-ins plus FIFO backpressure source.
  int rd_delay = 0, alu_delay = 0;
  logic [3:0] rd_addr_q;
  always @(negedge CLK) begin
    rf_rd_valid   = 1'b0;
    alu_out_valid = 1'b0;
    rf_rd_data    = DW'($urandom);
    alu_out       = 16'($urandom);
    fifo_full     = (full_mode == 1) || ((full_mode == 2) && ($urandom_range(0, 3) == 0));
    if (!RST) begin
      rd_delay  = 0;
      alu_delay = 0;
    end else begin
      if (rd_delay > 0) begin
        rd_delay--;
        if (rd_delay == 0) begin
          rf_rd_valid = 1'b1;
          rf_rd_data  = rf_mem[rd_addr_q];
        end
      end
      if (rf_rd_en) begin
        rd_addr_q = rf_addr;
        rd_delay  = $urandom_range(1, 3);
      end
      if (alu_delay > 0) begin
        alu_delay--;
        if (alu_delay == 0) begin
          alu_out_valid = 1'b1;
          alu_out       = alu_result;
        end
      end
      if (alu_en && !alu_hold) alu_delay = $urandom_range(1, 4);
    end
  end

  // Output monitor: every strobe must match the next expected transaction.
  always @(negedge CLK) begin
    if (RST) begin
      if (rf_wr_en) begin
        if (exp_wr.size() <= wr_idx) check("rf_wr_spurious", rf_wr_en, 0);
        else begin
          check("wr_addr", rf_addr, exp_wr[wr_idx][11:8]);
          check("wr_data", rf_wr_data, exp_wr[wr_idx][7:0]);
          wr_idx++;
        end
      end
      if (rf_rd_en) begin
        if (exp_rd.size() <= rd_idx) check("rf_rd_spurious", rf_rd_en, 0);
        else begin
          check("rd_addr", rf_addr, exp_rd[rd_idx]);
          rd_idx++;
        end
      end
      if (fifo_wr_en) begin
        fifo_writes++;
        check("wr_while_full", full_q, 0);
        check("gate_in_tx", gate_en, 0);
        if (exp_fifo.size() <= fifo_idx) check("fifo_spurious", fifo_wr_en, 0);
        else begin
          check("fifo_data", fifo_wr_data, exp_fifo[fifo_idx]);
          fifo_idx++;
        end
      end
      if (alu_en) begin
        check("gate_at_alu_en", gate_en, 1);
        if (exp_fun.size() <= fun_idx) check("alu_en_spurious", alu_en, 0);
        else begin
          check("alu_fun", alu_fun, exp_fun[fun_idx]);
          fun_idx++;
        end
      end
      if (err_opcode)  obs_err_op++;
      if (err_timeout) obs_err_to++;
    end
  end

  task automatic send(input logic [7:0] b);
    repeat ($urandom_range(0, max_gap)) @(negedge CLK);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge CLK);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  // Wait for the command to finish, injecting frames the DUT must ignore.
  task automatic finish_cmd(input string tag);
    int n = 0;
    while (busy && n < 6000) begin
      rx_valid = ($urandom_range(0, 3) == 0);
      rx_data  = 8'($urandom);
      @(negedge CLK);
      n++;
    end
    rx_valid = 1'b0;
    check({tag, "_done"}, busy, 0);
    @(negedge CLK);
    check({tag, "_wr_left"},   exp_wr.size() - wr_idx, 0);
    check({tag, "_rd_left"},   exp_rd.size() - rd_idx, 0);
    check({tag, "_fifo_left"}, exp_fifo.size() - fifo_idx, 0);
    check({tag, "_fun_left"},  exp_fun.size() - fun_idx, 0);
    check({tag, "_err_op"},    obs_err_op, exp_err_op);
    check({tag, "_err_to"},    obs_err_to, exp_err_to);
    check({tag, "_gate_idle"}, gate_en, 0);
  endtask

  task automatic do_wr(input logic [7:0] a, input logic [7:0] d);
    exp_wr.push_back({a[3:0], d});
    send(OPC_WR); send(a); send(d);
    finish_cmd("wr");
  endtask

  task automatic do_read(input logic [7:0] a, input logic [7:0] n, input bit single);
    int cnt = single ? 1 : ((n == 8'd0) ? 256 : int'(n));
    logic [3:0] ad;
    for (int i = 0; i < cnt; i++) begin
      ad = a[3:0] + 4'(i);
      exp_rd.push_back(ad);
      exp_fifo.push_back(rf_mem[ad]);
    end
    if (single) begin
      send(OPC_RD); send(a);
    end else begin
      send(OPC_BURST); send(a); send(n);
    end
    finish_cmd(single ? "rd" : "burst");
  endtask

  task automatic do_alu(input bit with_ops, input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] f, input logic [15:0] r);
    alu_result = r;
    if (with_ops) begin
      exp_wr.push_back({4'h0, x});
      exp_wr.push_back({4'h1, y});
    end
    exp_fun.push_back(f[3:0]);
    for (int i = 0; i < RES_BEATS; i++) exp_fifo.push_back(8'(r >> (8 * i)));
    if (with_ops) begin
      send(OPC_ALU_OP); send(x); send(y);
    end else begin
      send(OPC_ALU_NOP);
    end
    send(f);
    finish_cmd(with_ops ? "alu_op" : "alu_nop");
  endtask

  task automatic do_bad(input logic [7:0] op);
    exp_err_op++;
    send(op);
    finish_cmd("bad_op");
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int w0;
    int n;
    bit seen;
    logic [7:0] b;
    RST       = 1'b0;
    rx_valid  = 1'b0;
    rx_data   = '0;
    for (int i = 0; i < 16; i++) rf_mem[i] = 8'($urandom);
    repeat (3) @(negedge CLK);
    check("reset_outputs", outs, 0);
    RST = 1'b1;
    @(negedge CLK);
    check("idle_outputs", outs, 0);

    // Register write AA 05 3C.
    exp_wr.push_back({4'h5, 8'h3C});
    send(OPC_WR);
    check("wr_busy_mid", busy, 1);
    send(8'h05);
    send(8'h3C);
    check("wr_strobe", rf_wr_en, 1);
    check("wr_busy_end", busy, 0);
    finish_cmd("wr_dir");

    // Single read held off by a full FIFO for ten cycles.
    rf_mem[3] = 8'h7E;
    full_mode = 1;
    @(negedge CLK);
    exp_rd.push_back(4'h3);
    exp_fifo.push_back(8'h7E);
    w0 = fifo_writes;
    send(OPC_RD); send(8'h03);
    repeat (10) @(negedge CLK);
    check("bp_no_write", fifo_writes - w0, 0);
    check("bp_busy", busy, 1);
    full_mode = 0;
    finish_cmd("bp");
    check("bp_one_write", fifo_writes - w0, 1);

    // ALU with operands; gate_en only across FUN and ALU_WAIT.
    alu_result = 16'h0446;
    exp_wr.push_back({4'h0, 8'h12});
    exp_wr.push_back({4'h1, 8'h34});
    exp_fun.push_back(4'h1);
    exp_fifo.push_back(8'h46);
    exp_fifo.push_back(8'h04);
    send(OPC_ALU_OP); send(8'h12);
    check("gate_opb", gate_en, 0);
    send(8'h34);
    check("gate_fun", gate_en, 1);
    send(8'h01);
    check("gate_alu_wait", gate_en, 1);
    finish_cmd("alu_dir");

    // Burst with address wrap EE 0E 03.
    full_mode = 2;
    do_read(8'h0E, 8'h03, 1'b0);

    // Unknown opcode: one-cycle pulse, stays idle.
    exp_err_op++;
    send(8'h77);
    check("err_op_pulse", err_opcode, 1);
    check("err_op_idle", busy, 0);
    @(negedge CLK);
    check("err_op_once", err_opcode, 0);
    finish_cmd("err_op");

    // Frame timeout in WR_DATA: pulse, no write, back to idle.
    exp_err_to++;
    send(OPC_WR); send(8'h05);
    seen = 1'b0;
    n = 0;
    while (!seen && n < 200) begin
      @(negedge CLK);
      n++;
      seen = err_timeout;
    end
    check("to_seen", seen, 1);
    check("to_latency", (n >= int'(TO_LIMIT)) && (n <= int'(TO_LIMIT) + 1), 1);
    check("to_idle", busy, 0);
    @(negedge CLK);
    check("to_once", err_timeout, 0);
    finish_cmd("timeout");

    // Burst count 0 means 256 reads.
    do_read(8'($urandom), 8'h00, 1'b0);

    // Reset during ALU_WAIT aborts; next command decodes normally.
    alu_hold = 1'b1;
    exp_wr.push_back({4'h0, 8'h11});
    exp_wr.push_back({4'h1, 8'h22});
    exp_fun.push_back(4'h5);
    send(OPC_ALU_OP); send(8'h11); send(8'h22); send(8'h05);
    repeat (5) @(negedge CLK);
    check("abort_busy", busy, 1);
    check("abort_gate", gate_en, 1);
    RST = 1'b0;
    #1;
    check("abort_outputs", outs, 0);
    @(negedge CLK);
    RST = 1'b1;
    alu_hold = 1'b0;
    @(negedge CLK);
    check("abort_idle", outs, 0);
    do_alu(1'b1, 8'h5A, 8'hC3, 8'h29, 16'hBEEF);

    // Randomised command mix with gaps and random backpressure.
    max_gap = 3;
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 5))
        0: do_wr(8'($urandom), 8'($urandom));
        1: do_read(8'($urandom), 8'h00, 1'b1);
        2: do_read(8'($urandom), 8'($urandom_range(1, 5)), 1'b0);
        3: do_alu(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 16'($urandom));
        4: do_alu(1'b0, 8'h00, 8'h00, 8'($urandom), 16'($urandom));
        default: begin
          do b = 8'($urandom);
          while (b == OPC_WR || b == OPC_RD || b == OPC_ALU_OP ||
                 b == OPC_ALU_NOP || b == OPC_BURST);
          do_bad(b);
        end
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
